// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: default widths and the controller state encoding.
package ram_loader_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SET_ADDR,
        WRITE,
        VFY_ADDR,
        VFY_CHK,
        FINISH
    } state_t;

endpackage

// File: rtl/ram_loader_sum.sv
// Modulo-2^DATA_W byte accumulator with synchronous clear/add and a compare of the
// value it will hold after this cycle against another sum.
module ram_loader_sum
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] cmp_val,
    output logic [DATA_W-1:0] sum_nxt,
    output logic              match
);

    logic [DATA_W-1:0] sum;

    always_comb begin
        sum_nxt = sum;
        if (clr) begin
            sum_nxt = '0;
        end else if (add) begin
            sum_nxt = sum + value;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum <= '0;
        end else begin
            sum <= sum_nxt;
        end
    end

    // Looking at the next value lets the final verify read be included in the verdict.
    assign match = (sum_nxt == cmp_val);

endmodule

// File: rtl/ram_loader.sv
// Streams source bytes into a RAM through its address/write strobes, then optionally
// reads the block back and compares checksums.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mar_bus,
    output logic              mi,
    output logic [DATA_W-1:0] ram_bus,
    output logic              ri,
    input  logic [DATA_W-1:0] ram_value,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_q;
    logic              start_acc, take, addr_inc, vfy_clr, rb_add, err_chk;
    logic [DATA_W-1:0] wr_nxt, rb_nxt;
    logic              wr_match, rb_match;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mi        = 1'b0;
        ri        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        start_acc = 1'b0;
        take      = 1'b0;
        addr_inc  = 1'b0;
        vfy_clr   = 1'b0;
        rb_add    = 1'b0;
        err_chk   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take      = 1'b1;
                    state_nxt = SET_ADDR;
                end
            end
            SET_ADDR: begin
                mi        = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                ri = 1'b1;
                if (addr != len_q) begin
                    addr_inc  = 1'b1;
                    state_nxt = WAIT_BYTE;
                end else if (VERIFY != 0) begin
                    vfy_clr   = 1'b1;
                    state_nxt = VFY_ADDR;
                end else begin
                    state_nxt = FINISH;
                end
            end
            VFY_ADDR: begin
                mi        = 1'b1;
                state_nxt = VFY_CHK;
            end
            VFY_CHK: begin
                rb_add = 1'b1;
                if (addr != len_q) begin
                    addr_inc  = 1'b1;
                    state_nxt = VFY_ADDR;
                end else begin
                    err_chk   = 1'b1;
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                busy      = 1'b0;
                done      = !error;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything, including a byte offered in the same cycle.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            in_ready  = 1'b0;
            mi        = 1'b0;
            ri        = 1'b0;
            done      = 1'b0;
            take      = 1'b0;
            addr_inc  = 1'b0;
            vfy_clr   = 1'b0;
            rb_add    = 1'b0;
            err_chk   = 1'b0;
        end

        mar_bus = mi ? addr : '0;
        ram_bus = ri ? data_q : '0;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            len_q  <= '0;
            addr   <= '0;
            data_q <= '0;
            error  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                len_q <= len;
                addr  <= '0;
                error <= 1'b0;
            end
            if (take) begin
                data_q <= in_data;
            end
            if (addr_inc) begin
                addr <= addr + 1'b1;
            end
            if (vfy_clr) begin
                addr <= '0;
            end
            if (err_chk && !(wr_match && rb_match)) begin
                error <= 1'b1;
            end
        end
    end

    ram_loader_sum #(.DATA_W(DATA_W)) u_wr_sum (
        .clk     (clk),
        .clr_n   (clr_n),
        .clr     (start_acc),
        .add     (take),
        .value   (in_data),
        .cmp_val (rb_nxt),
        .sum_nxt (wr_nxt),
        .match   (wr_match)
    );

    ram_loader_sum #(.DATA_W(DATA_W)) u_rb_sum (
        .clk     (clk),
        .clr_n   (clr_n),
        .clr     (start_acc | vfy_clr),
        .add     (rb_add),
        .value   (ram_value),
        .cmp_val (wr_nxt),
        .sum_nxt (rb_nxt),
        .match   (rb_match)
    );

endmodule
